// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer words in a FIFO and hands them one at a time to the 32-bit uart.
// Define UART_TX_FEEDER_STATS_EN to build the sent_count completed-word counter.
module uart_tx_feeder #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 8,
    parameter int GAP_CYCLES     = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [DATA_W-1:0]        data_in,
    output logic                     start,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [15:0]              sent_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, GAP} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_level;
    logic [DATA_W-1:0] r_dataIn;
    logic              r_timeoutErr;
    logic [GW-1:0]     r_gapCnt;
    logic [TW-1:0]     r_timer;
    logic              w_push;
    logic              w_pop;
    logic              w_abort;
    logic              w_loadGap;

    // Flush beats push; a full FIFO refuses even if a pop frees a slot this cycle.
    assign in_ready = (r_level != LEVEL_FULL);
    assign w_push   = in_valid && in_ready && !flush;

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_abort     = 1'b0;
        w_loadGap   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_level != '0 && !flush) begin
                    w_pop       = 1'b1;
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    w_nextState = WAIT_LOW;
                end else if (TIMEOUT_CYCLES != 0 && r_timer == TIMER_LAST) begin
                    w_abort     = 1'b1;
                    w_nextState = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!tx_done) begin
                    if (GAP_CYCLES == 0) begin
                        w_nextState = IDLE;
                    end else begin
                        w_loadGap   = 1'b1;
                        w_nextState = GAP;
                    end
                end
            end
            GAP: begin
                if (r_gapCnt == '0) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // The timer restarts on every pop, so it only measures the current word's SEND time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dataIn     <= '0;
            r_timeoutErr <= 1'b0;
            r_timer      <= '0;
            r_gapCnt     <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_pop) begin
                r_dataIn <= r_mem[r_rdPtr];
                r_timer  <= '0;
            end else if (r_state == SEND) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_abort) begin
                r_timeoutErr <= 1'b1;
            end
            if (w_loadGap) begin
                r_gapCnt <= GAP_LOAD;
            end else if (r_state == GAP) begin
                r_gapCnt <= r_gapCnt - 1'b1;
            end
        end
    end

`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0] r_sentCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sentCount <= '0;
        end else if (r_state == SEND && tx_done) begin
            r_sentCount <= r_sentCount + 1'b1;
        end
    end

    assign sent_count = r_sentCount;
`else
    assign sent_count = '0;
`endif

    assign start       = (r_state == SEND);
    assign busy        = (r_state != IDLE) || (r_level != '0);
    assign fifo_level  = r_level;
    assign data_in     = r_dataIn;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed scoreboard bench for uart_tx_feeder with a behavioural uart handshake model.
// Honours UART_TX_FEEDER_STATS_EN when predicting sent_count.
module tb_uart_tx_feeder;
    localparam int DEPTH   = 8;
    localparam int GAP     = 5;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] data_in;
    logic        start;
    logic        tx_done;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        timeout_err;
    logic [15:0] sent_count;

    int          errors      = 0;
    int          checks      = 0;
    int          completions = 0;
    int          frameCycles = 8;
    bit          uartEnable  = 1'b1;
    logic [31:0] expQ [$];
    logic [31:0] curWord     = '0;

    uart_tx_feeder #(
        .DATA_W(32),
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .data_in(data_in),
        .start(start),
        .tx_done(tx_done),
        .fifo_level(fifo_level),
        .busy(busy),
        .timeout_err(timeout_err),
        .sent_count(sent_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic applyStimulus(input logic [31:0] word);
        in_data  = word;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) begin
            @(negedge clk);
        end
        checkOutput("push_ready", 32'(in_ready), 32'd1);
        expQ.push_back(word);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] expCount();
`ifdef UART_TX_FEEDER_STATS_EN
        return 32'(completions & 32'hFFFF);
`else
        return 32'd0;
`endif
    endfunction

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 1000 && busy !== 1'b0; i++) begin
            @(negedge clk);
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    // uart handshake model plus start-edge scoreboard, all sampled on the falling edge.
    initial begin
        int  cnt      = 0;
        int  lowRun   = 1000;
        bit  prevStart = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                lowRun    = 1000;
                prevStart = 1'b0;
                cnt       = 0;
                tx_done   = 1'b0;
            end else begin
                if (start === 1'b1 && !prevStart) begin
                    checks++;
                    assert (expQ.size() != 0) else begin
                        errors++;
                        $error("[TB] FAIL unexpected_start observed=%h expected=no start", data_in);
                    end
                    if (expQ.size() != 0) begin
                        curWord = expQ.pop_front();
                        checkOutput("word_data", data_in, curWord);
                    end
                    checkOutput("word_gap", 32'(lowRun >= GAP), 32'd1);
                end
                checkOutput("in_ready_vs_level", 32'(in_ready), 32'(fifo_level != 4'(DEPTH)));
                if (start === 1'b1) lowRun = 0;
                else                lowRun++;
                if (tx_done === 1'b1) begin
                    checkOutput("start_drop", 32'(start), 32'd0);
                    tx_done = 1'b0;
                    cnt     = 0;
                end else if (start === 1'b1 && uartEnable) begin
                    cnt++;
                    if (cnt >= frameCycles) begin
                        checkOutput("data_held", data_in, curWord);
                        tx_done = 1'b1;
                        completions++;
                    end
                end else begin
                    cnt = 0;
                end
                prevStart = (start === 1'b1);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          hi;
        logic [3:0]  lastLvl;
        logic        lastRdy;
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_data", data_in, 32'd0);
        checkOutput("rst_terr", 32'(timeout_err), 32'd0);
        checkOutput("rst_count", 32'(sent_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single word");
        frameCycles = 8;
        applyStimulus(32'hDEADBEEF);
        checkOutput("single_start_k", 32'(start), 32'd0);
        @(negedge clk);
        checkOutput("single_start_k1", 32'(start), 32'd1);
        checkOutput("single_data_k1", data_in, 32'hDEADBEEF);
        for (int i = 0; i < 100 && start === 1'b1; i++) @(negedge clk);
        checkOutput("single_start_fall", 32'(start), 32'd0);
        checkOutput("single_data_after", data_in, 32'hDEADBEEF);
        waitIdle("single_idle");
        checkOutput("single_count", 32'(sent_count), expCount());

        $display("[TB] burst fill and full push/pop");
        frameCycles = 12;
        for (int w = 0; w < 9; w++) applyStimulus(32'hB0000000 + 32'(w));
        checkOutput("burst_level_full", 32'(fifo_level), 32'd8);
        checkOutput("burst_ready_low", 32'(in_ready), 32'd0);
        in_data  = 32'hB0000009;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && start === 1'b1; i++) @(negedge clk);
        lastLvl = fifo_level;
        lastRdy = in_ready;
        for (int i = 0; i < 100 && start !== 1'b1; i++) begin
            lastLvl = fifo_level;
            lastRdy = in_ready;
            @(negedge clk);
        end
        checkOutput("full_idle_level", 32'(lastLvl), 32'd8);
        checkOutput("full_idle_ready", 32'(lastRdy), 32'd0);
        checkOutput("full_pop_level", 32'(fifo_level), 32'd7);
        checkOutput("full_pop_ready", 32'(in_ready), 32'd1);
        expQ.push_back(32'hB0000009);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("full_refill_level", 32'(fifo_level), 32'd8);
        waitIdle("burst_idle");
        checkOutput("burst_drained", 32'(expQ.size()), 32'd0);
        checkOutput("burst_count", 32'(sent_count), expCount());

        $display("[TB] timeout");
        uartEnable = 1'b0;
        applyStimulus(32'hA5A50001);
        in_data  = 32'hA5A50002;
        in_valid = 1'b1;
        expQ.push_back(32'hA5A50002);
        @(negedge clk);
        in_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 100 && start === 1'b1; i++) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("timeout_high_cycles", 32'(hi), 32'(TIMEOUT));
        checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
        uartEnable = 1'b1;
        waitIdle("timeout_idle");
        checkOutput("timeout_drained", 32'(expQ.size()), 32'd0);
        checkOutput("timeout_err_sticky", 32'(timeout_err), 32'd1);
        checkOutput("timeout_count", 32'(sent_count), expCount());

        $display("[TB] flush mid-transfer");
        frameCycles = 20;
        for (int w = 0; w < 4; w++) applyStimulus(32'hF1000000 + 32'(w));
        checkOutput("flush_in_send", 32'(start), 32'd1);
        checkOutput("flush_level_before", 32'(fifo_level), 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expQ.delete();
        checkOutput("flush_level", 32'(fifo_level), 32'd0);
        checkOutput("flush_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_data_kept", data_in, 32'hF1000000);
        waitIdle("flush_idle");
        checkOutput("flush_start_low", 32'(start), 32'd0);
        checkOutput("flush_count", 32'(sent_count), expCount());

        $display("[TB] reset during SEND");
        applyStimulus(32'hCAFE0001);
        for (int i = 0; i < 20 && start !== 1'b1; i++) @(negedge clk);
        checkOutput("rsend_in_send", 32'(start), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rsend_start", 32'(start), 32'd0);
        checkOutput("rsend_level", 32'(fifo_level), 32'd0);
        checkOutput("rsend_busy", 32'(busy), 32'd0);
        checkOutput("rsend_data", data_in, 32'd0);
        checkOutput("rsend_terr", 32'(timeout_err), 32'd0);
        checkOutput("rsend_count", 32'(sent_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        completions = 0;
        expQ.delete();
        frameCycles = 8;
        applyStimulus(32'h00000001);
        @(negedge clk);
        checkOutput("rsend_next_start", 32'(start), 32'd1);
        checkOutput("rsend_next_data", data_in, 32'h00000001);
        waitIdle("rsend_idle");
        checkOutput("rsend_next_count", 32'(sent_count), expCount());
        checkOutput("final_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
